cookie_sequencer: RTL and testbench
===================================

Name: cookie_sequencer

Overview:
- Control stage directly upstream of the cookie cell chain.
- Drives the chain's shared en/run/display/input_bit/display_shift_in lines through four phases:
  - serial seed load
  - N generations of life rules
  - display snapshot
  - serial readout
- Consumes the chain's output_bit and display_shift_out. Delivers the snapshot as a ready/valid pixel stream to the downstream output logic.

Parameters:
CHAIN_LEN, 64, number of cookie cells in the chain, i.e. bits per load and per readout.
GEN_W, 8, width of the generation-count input.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a frame; ignored unless idle
gen_count  input  GEN_W  generations to run; sampled on accepted start
seed_valid  input  1  seed bit offered
seed_bit  input  1  seed data, first bit = furthest cell
seed_ready  output  1  sequencer accepts seed bit
en  output  1  chain enable
run  output  1  chain life-rule step
display  output  1  chain snapshot pulse
input_bit  output  1  chain state shift input
display_shift_in  output  1  chain display shift input (always 0)
chain_out  input  1  output_bit of last cell
display_shift_out  input  1  display_shift_out of last cell
pix_valid  output  1  pixel offered
pix_data  output  1  pixel value
pix_last  output  1  final pixel of frame
pix_ready  input  1  downstream accepts pixel
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- States: IDLE, LOAD, RUN, SNAP, DUMP, DONE. One state register plus two counters:
  - bit_cnt (clog2(CHAIN_LEN+1) bits)
  - gen_cnt (GEN_W bits)
- Reset (async, rst_n=0): state=IDLE, counters=0. All outputs 0 while in reset and in IDLE.
- Outputs are decoded from state plus the current handshake. No output register stage.
- display_shift_in is tied to 0 in all states.
- IDLE:
  - start=1 captures gen_count into gen_cnt, clears bit_cnt, moves to LOAD next cycle.
  - start in any other state is ignored.
- LOAD:
  - seed_ready=1; en=seed_valid; input_bit=seed_bit; run=display=0.
  - Each cycle with seed_valid&seed_ready shifts the chain once and increments bit_cnt.
  - On the CHAIN_LEN-th accept:
    - gen_cnt==0 -> SNAP.
    - otherwise -> RUN.
  - seed_valid=0 holds the state with en=0 (no shift).
- RUN:
  - en=1, run=1, one generation per cycle.
  - gen_cnt decrements each cycle; leaves to SNAP in the cycle gen_cnt==1.
  - Exactly gen_count cycles of run=1.
- SNAP:
  - en=1, display=1 for exactly one cycle, then DUMP with bit_cnt cleared.
- DUMP:
  - pix_valid=1; pix_data=display_shift_out.
  - en=pix_ready; run=display=0.
  - input_bit=chain_out (recirculation), so the state chain is intact after CHAIN_LEN shifts.
  - Each pix_valid&pix_ready shifts both chains once and increments bit_cnt.
  - pix_last=1 while bit_cnt==CHAIN_LEN-1.
  - pix_ready=0 stalls with en=0; pix_data must stay stable during the stall.
  - After the CHAIN_LEN-th accept -> DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Ordering: the first pixel out is the cell holding the first loaded seed bit.
- Reset mid-frame: returns to IDLE immediately. No pulse of done. Chain contents undefined to the sequencer.
- Counters never wrap in normal operation.
- gen_count=2^GEN_W-1 must run the full count.

Test Plan:
All scenarios use CHAIN_LEN=4 and a bench-side behavioural chain model (4-bit state shift register, 4-bit display register, simple rule stub).
1. Reset with rst_n=0 mid-RUN -> all outputs 0 in the same cycle; busy=0; state IDLE after release.
2. start, gen_count=0; seed 1,0,1,1 with seed_valid continuous; pix_ready=1 -> exactly 4 en cycles in LOAD, 0 run cycles, 1 display cycle. Pixels 1,0,1,1 with pix_last on the 4th. done pulses one cycle later. Model state chain equals 1011 again.
3. gen_count=3 -> run=1 for exactly 3 consecutive cycles between the last seed accept and display=1.
4. seed_valid toggled 1,0,0,1,1,0,1 -> en only on accepted cycles; LOAD ends after the 4th accept.
5. pix_ready low for 5 cycles after the first pixel -> pix_valid held; pix_data stable; en=0 throughout the stall; total accepted pixels still 4.
6. start asserted during LOAD and again during DUMP -> ignored; one frame only, one done pulse. gen_count=255 with GEN_W=8 -> 255 run cycles.

Source files
------------

// File: rtl/cookie_sequencer.sv
// cookie_sequencer: control stage ahead of the cookie cell chain.
// Walks each frame through seed load, N life generations, a display
// snapshot and a serial pixel readout. Chain controls are decoded
// straight from state and the live handshakes.
module cookie_sequencer #(
  parameter int CHAIN_LEN = 64,
  parameter int GEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_count,
  input  logic             seed_valid,
  input  logic             seed_bit,
  output logic             seed_ready,
  output logic             en,
  output logic             run,
  output logic             display,
  output logic             input_bit,
  output logic             display_shift_in,
  input  logic             chain_out,
  input  logic             display_shift_out,
  output logic             pix_valid,
  output logic             pix_data,
  output logic             pix_last,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_SNAP, S_DUMP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gen_cnt_d = gen_cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        gen_cnt_d = gen_count;
        bit_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: if (seed_valid) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        // A zero generation count skips straight to the snapshot.
        if (bit_cnt_q == LAST) state_d = (gen_cnt_q == '0) ? S_SNAP : S_RUN;
      end
      S_RUN: begin
        gen_cnt_d = gen_cnt_q - GEN_W'(1);
        if (gen_cnt_q == GEN_W'(1)) state_d = S_SNAP;
      end
      S_SNAP: begin
        bit_cnt_d = '0;
        state_d   = S_DUMP;
      end
      S_DUMP: if (pix_ready) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Chain and stream controls, decoded from state plus handshake.
  always_comb begin
    seed_ready = 1'b0;
    en         = 1'b0;
    run        = 1'b0;
    display    = 1'b0;
    input_bit  = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = 1'b0;
    pix_last   = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        seed_ready = 1'b1;
        en         = seed_valid;
        input_bit  = seed_bit;
      end
      S_RUN: begin
        en  = 1'b1;
        run = 1'b1;
      end
      S_SNAP: begin
        en      = 1'b1;
        display = 1'b1;
      end
      S_DUMP: begin
        // Recirculate the state chain so it survives the readout.
        pix_valid = 1'b1;
        pix_data  = display_shift_out;
        pix_last  = (bit_cnt_q == LAST);
        en        = pix_ready;
        input_bit = chain_out;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign display_shift_in = 1'b0;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gen_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

endmodule

// File: tb/tb_cookie_sequencer.sv
// Bench for cookie_sequencer with a 4-cell behavioural chain and a
// frame-level expectation model built from load/run/snap/dump counts.
module tb_cookie_sequencer;
  localparam int N = 4;
  localparam int GW = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, seed_valid = 0, seed_bit = 0, pix_ready = 0;
  logic [GW-1:0] gen_count = '0;
  logic seed_ready, en, run, display, input_bit, display_shift_in;
  logic chain_out, display_shift_out, pix_valid, pix_data, pix_last, busy, done;

  always #5 clk = ~clk;

  cookie_sequencer #(.CHAIN_LEN(N), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gen_count(gen_count),
    .seed_valid(seed_valid), .seed_bit(seed_bit), .seed_ready(seed_ready),
    .en(en), .run(run), .display(display), .input_bit(input_bit),
    .display_shift_in(display_shift_in), .chain_out(chain_out),
    .display_shift_out(display_shift_out), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .busy(busy), .done(done));

  // Behavioural chain: cell 0 takes input, cell N-1 is the output end.
  // Rule stub: one generation inverts every cell.
  logic [N-1:0] st = '0, dp = '0;
  assign chain_out = st[N-1];
  assign display_shift_out = dp[N-1];
  always @(posedge clk) begin
    if (en) begin
      if (run) st <= ~st;
      else if (display) dp <= st;
      else begin
        st <= {st[N-2:0], input_bit};
        dp <= {dp[N-2:0], display_shift_in};
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  // Frame model: progress is measured in accepted seeds, generations,
  // snapshot taken and pixels accepted.
  int m_busy = 0, m_loaded = 0, m_runs = 0, m_snap = 0, m_pix = 0, m_g = 0;
  logic m_seeds [N];
  // Observed frame statistics for the directed literal checks.
  int s_load_en, s_load_cyc, s_run, s_run_streak, s_run_max, s_disp, s_pix, s_stall, s_done, s_last_idx;
  logic [N-1:0] s_word;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, then advance the model.
  task automatic tick();
    logic [8:0] e, a;
    int ph;  // 0 idle, 1 load, 2 run, 3 snap, 4 dump, 5 done
    @(negedge clk);
    if (!rst_n || m_busy == 0) ph = 0;
    else if (m_loaded < N) ph = 1;
    else if (m_runs < m_g) ph = 2;
    else if (m_snap == 0) ph = 3;
    else if (m_pix < N) ph = 4;
    else ph = 5;
    e = '0;
    case (ph)
      1: e = {1'b1, seed_valid, 7'b0};
      2: e = {1'b0, 1'b1, 1'b1, 6'b0};
      3: e = {1'b0, 1'b1, 1'b0, 1'b1, 5'b0};
      4: e = {1'b0, pix_ready, 2'b0, 1'b1, (m_pix == N-1), 3'b0};
      default: e = '0;
    endcase
    if (ph != 0) e[2] = 1'b1;
    if (ph == 5) e[1] = 1'b1;
    a = {seed_ready, en, run, display, pix_valid, pix_last, busy, done, display_shift_in};
    chk("ctrl", int'(a), int'(e));
    if (ph == 1) chk("input_bit_load", input_bit, seed_bit);
    if (ph == 4) begin
      chk("input_bit_dump", input_bit, chain_out);
      chk("pix_data", pix_data, m_seeds[m_pix] ^ m_g[0]);
    end
    if (done) s_done++;
    if (run) begin s_run++; s_run_streak++; if (s_run_streak > s_run_max) s_run_max = s_run_streak; end
    else s_run_streak = 0;
    if (display) s_disp++;
    case (ph)
      0: if (rst_n && start) begin
        m_busy = 1; m_g = int'(gen_count); m_loaded = 0; m_runs = 0; m_snap = 0; m_pix = 0;
        s_load_en = 0; s_load_cyc = 0; s_run = 0; s_run_streak = 0; s_run_max = 0;
        s_disp = 0; s_pix = 0; s_stall = 0; s_done = 0; s_last_idx = -1; s_word = '0;
      end
      1: begin
        s_load_cyc++;
        if (en) s_load_en++;
        if (seed_valid) begin m_seeds[m_loaded] = seed_bit; m_loaded++; end
      end
      2: m_runs++;
      3: m_snap = 1;
      4: if (pix_ready) begin
        s_word = {s_word[N-2:0], pix_data};
        if (pix_last) s_last_idx = s_pix;
        s_pix++; m_pix++;
      end else if (!en) s_stall++;
      default: m_busy = 0;
    endcase
    if (!rst_n) m_busy = 0;
    @(posedge clk); #1;
  endtask

  // One frame. sd[N-1] is the first seed bit sent. Optional seed_valid
  // pattern, random handshakes, a 5-cycle stall after pixel 0, stray
  // starts, or a reset once the frame is two generations into RUN.
  task automatic frame(input int g, input logic [N-1:0] sd, input logic [15:0] pat,
                       input int plen, input bit rnd, input bit stall, input bit xs,
                       input bit rst_mid);
    int st_cnt = 0;
    start = 1; gen_count = GW'(g);
    tick();
    start = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_busy == 0) break;
      seed_bit   = (m_loaded < N) ? sd[N-1-m_loaded] : 1'b0;
      seed_valid = (i < plen) ? pat[i] : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      pix_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && m_pix == 1 && st_cnt < 5) begin pix_ready = 0; st_cnt++; end
      start = xs && (i == 1 || m_pix == 2);
      if (rst_mid && m_loaded == N && m_runs >= 2) begin
        rst_n = 0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", int'({en, run, display, seed_ready, pix_valid, done}), 0);
        tick(); tick();
        rst_n = 1;
        break;
      end
      tick();
      if (i == 1999) chk("frame_timeout", 1, 0);
    end
    start = 0; seed_valid = 0; pix_ready = 0;
  endtask

  initial begin
    logic [N-1:0] sd;
    int g;
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    rst_n = 1;
    tick();
    chk("idle_outs", int'({seed_ready, en, run, display, pix_valid, done}), 0);

    // Reset while in RUN.
    frame(10, 4'b0110, '0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    chk("rst_idle_after", busy, 0);
    chk("rst_no_done", s_done, 0);

    // gen_count=0, seed 1,0,1,1.
    frame(0, 4'b1011, '0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_load_en", s_load_en, 4);
    chk("t2_run", s_run, 0);
    chk("t2_disp", s_disp, 1);
    chk("t2_pixels", int'(s_word), 4'b1011);
    chk("t2_last_idx", s_last_idx, 3);
    chk("t2_done", s_done, 1);
    chk("t2_chain", int'(st), 4'b1011);

    // gen_count=3: three consecutive generations, inverted pixels.
    frame(3, 4'b1011, '0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_run", s_run, 3);
    chk("t3_run_streak", s_run_max, 3);
    chk("t3_pixels", int'(s_word), 4'b0100);

    // seed_valid 1,0,0,1,1,0,1.
    frame(1, 4'b1100, 16'b1011001, 7, 0, 0, 0, 0);
    tick();
    chk("t4_load_en", s_load_en, 4);
    chk("t4_load_cyc", s_load_cyc, 7);
    chk("t4_pixels", int'(s_word), 4'b0011);

    // Five-cycle stall after the first pixel.
    frame(2, 4'b1001, '0, 0, 0, 1, 0, 0);
    tick();
    chk("t5_stall", s_stall, 5);
    chk("t5_pix", s_pix, 4);
    chk("t5_pixels", int'(s_word), 4'b1001);

    // Stray starts and the maximum generation count.
    frame(255, 4'b0111, '0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    chk("t6_run", s_run, 255);
    chk("t6_done", s_done, 1);
    chk("t6_idle", busy, 0);
    chk("t6_pixels", int'(s_word), 4'b1000);

    // Random frames with random handshakes.
    for (int k = 0; k < 8; k++) begin
      sd = N'($urandom);
      g = $urandom_range(0, 6);
      frame(g, sd, '0, 0, 1, 0, 0, 0);
      tick();
      chk("rnd_pixels", int'(s_word), int'(sd ^ {N{g[0]}}));
      chk("rnd_chain", int'(st), int'(sd ^ {N{g[0]}}));
      chk("rnd_done", s_done, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
